c499_locked_sec: RTL and testbench



---
 rtl/c499_locked_sec.sv | 200 ++++++++++++++++++++
 tb/tb_c499_locked_sec.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/c499_locked_sec.sv
// c499_locked_sec
//   Logic-locked 32-bit single-error-correcting decoder, modelled on the
//   ISCAS-85 c499 benchmark, with a registered corrected-data output.
//
//   A syndrome is formed from 32 data bits and 8 check bits. When correction
//   is enabled, the data bit whose parity-check column equals the syndrome is
//   flipped. A 16-bit key is compared against a fixed constant:
//     - The low mismatch byte perturbs the syndrome before decode.
//     - The high mismatch byte is XORed into every byte of the output.
//   Only the correct key gives the true decoder function.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset; clears the outputs to 0
//   keyinput2     16-bit locking key
//   N1..N125      data bits ID[i] = N(4i+1), i = 0..31
//   N129..N136    check bits IC[j] = N(129+j), j = 0..7
//   N137          correction enable R
//   N724..N755    corrected data OD[i] = N(724+i), registered
module c499_locked_sec (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] keyinput2,
  input  logic        N1,
  input  logic        N5,
  input  logic        N9,
  input  logic        N13,
  input  logic        N17,
  input  logic        N21,
  input  logic        N25,
  input  logic        N29,
  input  logic        N33,
  input  logic        N37,
  input  logic        N41,
  input  logic        N45,
  input  logic        N49,
  input  logic        N53,
  input  logic        N57,
  input  logic        N61,
  input  logic        N65,
  input  logic        N69,
  input  logic        N73,
  input  logic        N77,
  input  logic        N81,
  input  logic        N85,
  input  logic        N89,
  input  logic        N93,
  input  logic        N97,
  input  logic        N101,
  input  logic        N105,
  input  logic        N109,
  input  logic        N113,
  input  logic        N117,
  input  logic        N121,
  input  logic        N125,
  input  logic        N129,
  input  logic        N130,
  input  logic        N131,
  input  logic        N132,
  input  logic        N133,
  input  logic        N134,
  input  logic        N135,
  input  logic        N136,
  input  logic        N137,
  output logic        N724,
  output logic        N725,
  output logic        N726,
  output logic        N727,
  output logic        N728,
  output logic        N729,
  output logic        N730,
  output logic        N731,
  output logic        N732,
  output logic        N733,
  output logic        N734,
  output logic        N735,
  output logic        N736,
  output logic        N737,
  output logic        N738,
  output logic        N739,
  output logic        N740,
  output logic        N741,
  output logic        N742,
  output logic        N743,
  output logic        N744,
  output logic        N745,
  output logic        N746,
  output logic        N747,
  output logic        N748,
  output logic        N749,
  output logic        N750,
  output logic        N751,
  output logic        N752,
  output logic        N753,
  output logic        N754,
  output logic        N755
);

  localparam int          DATA_W = 32;
  localparam int          CHK_W  = 8;
  localparam logic [15:0] KEY    = 16'h795E;

  // Parity-check column of data bit i:
  //   - The upper nibble is one-hot on the group i[4:3].
  //   - The lower nibble is a weight-2 or weight-3 pattern chosen by i[2:0].
  // Every column therefore has weight 3 or 4, so it can never alias a
  // single check-bit error (weight 1).
  function automatic logic [CHK_W-1:0] col_of(input logic [4:0] idx);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'b0001 << idx[4:3];
    case (idx[2:0])
      3'd0:    lo = 4'h3;
      3'd1:    lo = 4'h5;
      3'd2:    lo = 4'h6;
      3'd3:    lo = 4'h9;
      3'd4:    lo = 4'hA;
      3'd5:    lo = 4'hC;
      3'd6:    lo = 4'h7;
      default: lo = 4'hB;
    endcase
    return {hi, lo};
  endfunction

  logic [DATA_W-1:0] id_p0;
  logic [CHK_W-1:0]  ic_p0;
  logic              r_p0;
  logic [15:0]       mask_p0;
  logic [CHK_W-1:0]  syn_p0;
  logic [CHK_W-1:0]  sd_p0;
  logic [DATA_W-1:0] d_p0;
  logic [DATA_W-1:0] od_p1;

  assign id_p0 = {N125, N121, N117, N113, N109, N105, N101, N97,
                  N93,  N89,  N85,  N81,  N77,  N73,  N69,  N65,
                  N61,  N57,  N53,  N49,  N45,  N41,  N37,  N33,
                  N29,  N25,  N21,  N17,  N13,  N9,   N5,   N1};
  assign ic_p0   = {N136, N135, N134, N133, N132, N131, N130, N129};
  assign r_p0    = N137;
  assign mask_p0 = keyinput2 ^ KEY;

  // Stage p0: syndrome, key-perturbed decode and correction (combinational)
  always_comb begin
    syn_p0 = ic_p0;
    for (int i = 0; i < DATA_W; i++) begin
      syn_p0 = syn_p0 ^ (col_of(5'(i)) & {CHK_W{id_p0[i]}});
    end
    sd_p0 = syn_p0 ^ mask_p0[7:0];
    d_p0  = '0;
    for (int i = 0; i < DATA_W; i++) begin
      // mask_p0[15:8] is replicated across all four bytes of the word.
      d_p0[i] = id_p0[i]
              ^ (r_p0 && (sd_p0 == col_of(5'(i))))
              ^ mask_p0[8 + (i % 8)];
    end
  end

  // Stage p1: output register, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      od_p1 <= '0;
    end else begin
      od_p1 <= d_p0;
    end
  end

  assign N724 = od_p1[0];
  assign N725 = od_p1[1];
  assign N726 = od_p1[2];
  assign N727 = od_p1[3];
  assign N728 = od_p1[4];
  assign N729 = od_p1[5];
  assign N730 = od_p1[6];
  assign N731 = od_p1[7];
  assign N732 = od_p1[8];
  assign N733 = od_p1[9];
  assign N734 = od_p1[10];
  assign N735 = od_p1[11];
  assign N736 = od_p1[12];
  assign N737 = od_p1[13];
  assign N738 = od_p1[14];
  assign N739 = od_p1[15];
  assign N740 = od_p1[16];
  assign N741 = od_p1[17];
  assign N742 = od_p1[18];
  assign N743 = od_p1[19];
  assign N744 = od_p1[20];
  assign N745 = od_p1[21];
  assign N746 = od_p1[22];
  assign N747 = od_p1[23];
  assign N748 = od_p1[24];
  assign N749 = od_p1[25];
  assign N750 = od_p1[26];
  assign N751 = od_p1[27];
  assign N752 = od_p1[28];
  assign N753 = od_p1[29];
  assign N754 = od_p1[30];
  assign N755 = od_p1[31];

endmodule

// File: tb/tb_c499_locked_sec.sv
// Directed testbench for c499_locked_sec.
module tb_c499_locked_sec;

  localparam logic [15:0] KEY = 16'h795E;

  logic        clk;
  logic        rst_n;
  logic [15:0] key;
  logic [31:0] id;
  logic [7:0]  ic;
  logic        r;
  wire  [31:0] od;

  int checks;
  int errors;

  c499_locked_sec dut (
    .clk(clk), .rst_n(rst_n), .keyinput2(key),
    .N1(id[0]),    .N5(id[1]),    .N9(id[2]),    .N13(id[3]),
    .N17(id[4]),   .N21(id[5]),   .N25(id[6]),   .N29(id[7]),
    .N33(id[8]),   .N37(id[9]),   .N41(id[10]),  .N45(id[11]),
    .N49(id[12]),  .N53(id[13]),  .N57(id[14]),  .N61(id[15]),
    .N65(id[16]),  .N69(id[17]),  .N73(id[18]),  .N77(id[19]),
    .N81(id[20]),  .N85(id[21]),  .N89(id[22]),  .N93(id[23]),
    .N97(id[24]),  .N101(id[25]), .N105(id[26]), .N109(id[27]),
    .N113(id[28]), .N117(id[29]), .N121(id[30]), .N125(id[31]),
    .N129(ic[0]), .N130(ic[1]), .N131(ic[2]), .N132(ic[3]),
    .N133(ic[4]), .N134(ic[5]), .N135(ic[6]), .N136(ic[7]),
    .N137(r),
    .N724(od[0]),  .N725(od[1]),  .N726(od[2]),  .N727(od[3]),
    .N728(od[4]),  .N729(od[5]),  .N730(od[6]),  .N731(od[7]),
    .N732(od[8]),  .N733(od[9]),  .N734(od[10]), .N735(od[11]),
    .N736(od[12]), .N737(od[13]), .N738(od[14]), .N739(od[15]),
    .N740(od[16]), .N741(od[17]), .N742(od[18]), .N743(od[19]),
    .N744(od[20]), .N745(od[21]), .N746(od[22]), .N747(od[23]),
    .N748(od[24]), .N749(od[25]), .N750(od[26]), .N751(od[27]),
    .N752(od[28]), .N753(od[29]), .N754(od[30]), .N755(od[31])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [31:0] d, input logic [7:0] c,
                       input logic en, input logic [15:0] k);
    id  = d;
    ic  = c;
    r   = en;
    key = k;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(32'hDEADBEEF, 8'hA5, 1'b1, 16'h1234);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (od !== 32'h0) begin
      errors++;
      $display("FAIL reset_async od=%h expected=%h", od, 32'h0);
    end
    tick();
    checks++;
    if (od !== 32'h0) begin
      errors++;
      $display("FAIL reset_held od=%h expected=%h", od, 32'h0);
    end
    drive(32'h45678969, 8'h00, 1'b0, KEY);
    rst_n = 1'b1;
    tick();
    checks++;
    if (od !== 32'h45678969) begin
      errors++;
      $display("FAIL reset_release od=%h expected=%h", od, 32'h45678969);
    end
  endtask

  task automatic test_passthrough();
    drive(32'h45678969, 8'h00, 1'b0, KEY);
    tick();
    checks++;
    if (od !== 32'h45678969) begin
      errors++;
      $display("FAIL passthrough_r0 od=%h expected=%h", od, 32'h45678969);
    end
    // R = 0 must not correct even a single-bit syndrome.
    drive(32'h00000001, 8'h00, 1'b0, KEY);
    tick();
    checks++;
    if (od !== 32'h00000001) begin
      errors++;
      $display("FAIL no_correct_r0 od=%h expected=%h", od, 32'h00000001);
    end
  endtask

  // Consecutive cycles each carry a different single-bit error.
  task automatic test_data_correction();
    for (int i = 0; i < 32; i++) begin
      drive(32'h1 << i, 8'h00, 1'b1, KEY);
      tick();
      checks++;
      if (od !== 32'h0) begin
        errors++;
        $display("FAIL data_corr bit=%0d od=%h expected=%h", i, od, 32'h0);
      end
    end
  endtask

  // All-ones data with zero check bits is a valid codeword.
  task automatic test_nonzero_codeword();
    drive(32'hFFFFFFFF, 8'h00, 1'b1, KEY);
    tick();
    checks++;
    if (od !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL ones_clean od=%h expected=%h", od, 32'hFFFFFFFF);
    end
    for (int i = 0; i < 32; i += 5) begin
      drive(~(32'h1 << i), 8'h00, 1'b1, KEY);
      tick();
      checks++;
      if (od !== 32'hFFFFFFFF) begin
        errors++;
        $display("FAIL ones_corr bit=%0d od=%h expected=%h", i, od, 32'hFFFFFFFF);
      end
    end
  endtask

  task automatic test_check_bit();
    for (int j = 0; j < 8; j++) begin
      drive(32'h0, 8'h1 << j, 1'b1, KEY);
      tick();
      checks++;
      if (od !== 32'h0) begin
        errors++;
        $display("FAIL check_bit j=%0d od=%h expected=%h", j, od, 32'h0);
      end
    end
  endtask

  // Bits 0 and 1: syndrome 0x13^0x15 = 0x06 matches no column.
  task automatic test_multibit();
    drive(32'h00000003, 8'h00, 1'b1, KEY);
    tick();
    checks++;
    if (od !== 32'h00000003) begin
      errors++;
      $display("FAIL multibit od=%h expected=%h", od, 32'h00000003);
    end
  endtask

  task automatic test_wrong_key();
    logic [15:0] keys [10];
    logic [7:0]  hb;
    logic [31:0] exp;
    keys = '{16'h0000, 16'hFFFF, 16'h1234, 16'hA5A5, 16'h395E,
             16'h785E, 16'h7B5E, 16'h695E, 16'hF95E, 16'h7A00};
    drive(32'h0, 8'h00, 1'b0, 16'h0000);
    tick();
    checks++;
    if (od !== 32'h79797979) begin
      errors++;
      $display("FAIL wrong_key_zero od=%h expected=%h", od, 32'h79797979);
    end
    for (int n = 0; n < 10; n++) begin
      hb  = keys[n][15:8] ^ 8'h79;
      exp = 32'h45678969 ^ {4{hb}};
      drive(32'h45678969, 8'h00, 1'b0, keys[n]);
      tick();
      checks++;
      if (od !== exp || od === 32'h45678969) begin
        errors++;
        $display("FAIL wrong_key k=%h od=%h expected=%h", keys[n], od, exp);
      end
    end
    // Low mismatch byte 0x13 equals col_0, so a clean zero word gets bit 0 flipped.
    drive(32'h0, 8'h00, 1'b1, 16'h794D);
    tick();
    checks++;
    if (od !== 32'h00000001) begin
      errors++;
      $display("FAIL wrong_key_syn od=%h expected=%h", od, 32'h00000001);
    end
  endtask

  task automatic test_key_restore();
    drive(32'h45678969, 8'h00, 1'b0, 16'h0000);
    tick();
    drive(32'h45678969, 8'h00, 1'b0, KEY);
    #1;
    checks++;
    if (od !== 32'h3C1EF010) begin
      errors++;
      $display("FAIL key_restore_hold od=%h expected=%h", od, 32'h3C1EF010);
    end
    tick();
    checks++;
    if (od !== 32'h45678969) begin
      errors++;
      $display("FAIL key_restore od=%h expected=%h", od, 32'h45678969);
    end
  endtask

  task automatic test_midop_reset();
    drive(32'hFFFFFFFF, 8'h00, 1'b1, KEY);
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (od !== 32'h0) begin
      errors++;
      $display("FAIL midop_reset od=%h expected=%h", od, 32'h0);
    end
    tick();
    checks++;
    if (od !== 32'h0) begin
      errors++;
      $display("FAIL midop_held od=%h expected=%h", od, 32'h0);
    end
    #2 rst_n = 1'b1;
    #1;
    checks++;
    if (od !== 32'h0) begin
      errors++;
      $display("FAIL midop_release_noedge od=%h expected=%h", od, 32'h0);
    end
    tick();
    checks++;
    if (od !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL midop_resume od=%h expected=%h", od, 32'hFFFFFFFF);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    drive(32'h0, 8'h00, 1'b0, KEY);
    test_reset();
    test_passthrough();
    test_data_correction();
    test_nonzero_codeword();
    test_check_bit();
    test_multibit();
    test_wrong_key();
    test_key_restore();
    test_midop_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
